// File: rtl/multisim_client_push_packer.sv
// multisim_client_push_packer
//
// Packs narrow IN_WIDTH beats into one DATA_WIDTH word for the client push stage.
// Beat k of a word lands in lane k (first beat in the LSBs). Unfilled lanes are zero.
// in_last closes a partial word early. in_rdy is a register output, so the client's
// data_rdy (out_rdy) has no combinational path back to the beat source.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous reset, active-high
//   in_vld     input beat valid
//   in_rdy     input beat ready (registered)
//   in_data    input beat
//   in_last    closes the current word after this beat (qualified by in_vld)
//   out_vld    packed word valid (client push data_vld)
//   out_rdy    packed word ready (client push data_rdy)
//   out_data   packed word
//   out_beats  number of valid beats in out_data, 1..RATIO
module multisim_client_push_packer #(
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH = 64,
    localparam int unsigned RATIO     = DATA_WIDTH / IN_WIDTH,
    localparam int unsigned CNT_WIDTH = $clog2(RATIO) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_last,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_beats
);

    if ((DATA_WIDTH % IN_WIDTH) != 0) begin : gen_width_check
        $error("DATA_WIDTH must be an integer multiple of IN_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] LastBeat = CNT_WIDTH'(RATIO - 1);

    typedef enum logic [0:0] {StOpen, StClosed} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_data_q, acc_data_d;
    // In StClosed beat_cnt_q holds (beats - 1) of the parked word.
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  in_rdy_q, in_rdy_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]  out_beats_q, out_beats_d;

    logic                  in_fire;
    logic                  out_fire;
    logic                  out_free;
    logic [DATA_WIDTH-1:0] lane_word;

    assign in_rdy    = in_rdy_q;
    assign out_vld   = out_vld_q;
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;

    // in_rdy_q is only set in StOpen, so it alone qualifies the input handshake.
    assign in_fire  = in_vld & in_rdy_q;
    assign out_fire = out_vld_q & out_rdy;
    assign out_free = ~out_vld_q | out_rdy;

    // Accumulator with the current beat inserted into lane beat_cnt_q.
    always_comb begin
        lane_word = acc_data_q;
        for (int k = 0; k < int'(RATIO); k++) begin
            if (CNT_WIDTH'(k) == beat_cnt_q) begin
                lane_word[k*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_data_d  = acc_data_q;
        beat_cnt_d  = beat_cnt_q;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;

        if (out_fire) begin
            out_vld_d = 1'b0;
        end

        unique case (state_q)
            StOpen: begin
                if (in_fire) begin
                    if (in_last || (beat_cnt_q == LastBeat)) begin
                        if (out_free) begin
                            out_vld_d   = 1'b1;
                            out_data_d  = lane_word;
                            out_beats_d = beat_cnt_q + CNT_WIDTH'(1);
                            acc_data_d  = '0;
                            beat_cnt_d  = '0;
                        end else begin
                            // Park the finished word; beat_cnt_q keeps its size.
                            acc_data_d = lane_word;
                            state_d    = StClosed;
                        end
                    end else begin
                        acc_data_d = lane_word;
                        beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            StClosed: begin
                if (out_fire) begin
                    out_vld_d   = 1'b1;
                    out_data_d  = acc_data_q;
                    out_beats_d = beat_cnt_q + CNT_WIDTH'(1);
                    acc_data_d  = '0;
                    beat_cnt_d  = '0;
                    state_d     = StOpen;
                end
            end
            default: state_d = StOpen;
        endcase

        in_rdy_d = (state_d == StOpen);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StOpen;
            acc_data_q  <= '0;
            beat_cnt_q  <= '0;
            in_rdy_q    <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_data_q  <= acc_data_d;
            beat_cnt_q  <= beat_cnt_d;
            in_rdy_q    <= in_rdy_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
        end
    end

endmodule

// File: tb/tb_multisim_client_push_packer.sv
// Testbench for multisim_client_push_packer.
// Main instance: IN_WIDTH=8, DATA_WIDTH=64. Second instance: RATIO=1 (IN_WIDTH=64).
// A queue-based model of completed-but-unconsumed words predicts every output each cycle.
module tb_multisim_client_push_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance signals
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic [63:0] out_data;
    logic [3:0]  out_beats;

    // RATIO=1 instance signals
    logic        in_vld1 = 1'b0;
    logic        in_rdy1;
    logic [63:0] in_data1 = '0;
    logic        in_last1 = 1'b0;
    logic        out_vld1;
    logic        out_rdy1 = 1'b1;
    logic [63:0] out_data1;
    logic [0:0]  out_beats1;

    multisim_client_push_packer #(.IN_WIDTH(8), .DATA_WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_beats (out_beats)
    );

    multisim_client_push_packer #(.IN_WIDTH(64), .DATA_WIDTH(64)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld1),
        .in_rdy    (in_rdy1),
        .in_data   (in_data1),
        .in_last   (in_last1),
        .out_vld   (out_vld1),
        .out_rdy   (out_rdy1),
        .out_data  (out_data1),
        .out_beats (out_beats1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int stalls = 0;
    bit run1 = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        int          b;
    } word_t;

    // ---------------- reference model, main instance ----------------
    word_t      exp_q[$];
    logic [7:0] part[$];
    bit         m_rst = 1'b1;

    always @(negedge clk) begin
        bit    m_rdy;
        word_t w;
        check("out_vld", out_vld, 64'(exp_q.size() > 0));
        check("in_rdy", in_rdy, 64'(!m_rst && exp_q.size() < 2));
        if (exp_q.size() > 0) begin
            check("out_data", out_data, exp_q[0].d);
            check("out_beats", 64'(out_beats), 64'(exp_q[0].b));
        end else if (m_rst) begin
            check("rst_out_data", out_data, 64'd0);
            check("rst_out_beats", 64'(out_beats), 64'd0);
        end
        if (rst) begin
            exp_q.delete();
            part.delete();
            m_rst = 1'b1;
        end else begin
            m_rdy = !m_rst && exp_q.size() < 2;
            if (exp_q.size() > 0 && out_rdy) void'(exp_q.pop_front());
            if (in_vld && m_rdy) begin
                part.push_back(in_data);
                if (in_last || part.size() == 8) begin
                    w.d = '0;
                    foreach (part[k]) w.d[k*8 +: 8] = part[k];
                    w.b = part.size();
                    exp_q.push_back(w);
                    part.delete();
                end
            end
            m_rst = 1'b0;
        end
    end

    // ---------------- reference model, RATIO=1 instance ----------------
    word_t q1[$];
    bit    m1_rst = 1'b1;

    always @(negedge clk) begin
        bit    m_rdy;
        word_t w;
        check("r1_out_vld", out_vld1, 64'(q1.size() > 0));
        check("r1_in_rdy", in_rdy1, 64'(!m1_rst && q1.size() < 2));
        if (q1.size() > 0) begin
            check("r1_out_data", out_data1, q1[0].d);
            check("r1_out_beats", 64'(out_beats1), 64'd1);
        end
        if (rst) begin
            q1.delete();
            m1_rst = 1'b1;
        end else begin
            m_rdy = !m1_rst && q1.size() < 2;
            if (q1.size() > 0 && out_rdy1) void'(q1.pop_front());
            if (in_vld1 && m_rdy) begin
                w.d = in_data1;
                w.b = 1;
                q1.push_back(w);
            end
            m1_rst = 1'b0;
        end
    end

    // Random traffic for the RATIO=1 instance for the whole run.
    initial begin
        while (run1) begin
            @(posedge clk);
            #1;
            in_vld1  = ($urandom_range(0, 3) != 0);
            in_data1 = {$urandom, $urandom};
            in_last1 = $urandom_range(0, 1) == 1;
            out_rdy1 = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat until accepted (bounded); leaves in_vld low afterwards.
    task automatic send_beat(input logic [7:0] d, input logic last);
        int   n = 0;
        logic acc;
        in_vld  = 1'b1;
        in_data = d;
        in_last = last;
        do begin
            acc = in_rdy;
            tick();
            n++;
        end while (!acc && n < 100);
        check("beat_accepted", 64'(acc), 64'd1);
        if (n > 1) stalls += n - 1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) tick();
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_rdy", 64'(in_rdy), 64'd1);

        // Full word with out_rdy=1
        out_rdy = 1'b1;
        for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0);
        check("full_vld", 64'(out_vld), 64'd1);
        check("full_data", out_data, 64'h0807060504030201);
        check("full_beats", 64'(out_beats), 64'd8);
        tick();
        check("full_vld_1cyc", 64'(out_vld), 64'd0);

        // Partial flush, then 1-beat word from lane 0
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b0);
        send_beat(8'hCC, 1'b1);
        check("part_data", out_data, 64'h0000000000CCBBAA);
        check("part_beats", 64'(out_beats), 64'd3);
        send_beat(8'h5A, 1'b1);
        check("one_data", out_data, 64'h5A);
        check("one_beats", 64'(out_beats), 64'd1);
        tick();

        // Backpressure
        out_rdy = 1'b0;
        for (int i = 0; i < 16; i++) send_beat(8'(i), 1'b0);
        check("bp_closed", 64'(in_rdy), 64'd0);
        check("bp_word0", out_data, 64'h0706050403020100);
        repeat (3) tick();
        check("bp_hold", out_data, 64'h0706050403020100);
        out_rdy = 1'b1;
        tick();
        check("bp_word1", out_data, 64'h0F0E0D0C0B0A0908);
        check("bp_reopen", 64'(in_rdy), 64'd1);
        tick();
        check("bp_drained", 64'(out_vld), 64'd0);

        // in_last on the 8th beat is a full word
        for (int i = 0; i < 8; i++) send_beat(8'(8'h21 + i), i == 7);
        check("last8_beats", 64'(out_beats), 64'd8);
        check("last8_data", out_data, 64'h2827262524232221);
        tick();

        // Streaming 64 beats
        stalls = 0;
        for (int i = 0; i < 64; i++) send_beat(8'($urandom), 1'b0);
        check("stream_stalls", 64'(stalls), 64'd0);
        tick();

        // Reset mid-word
        for (int i = 0; i < 5; i++) send_beat(8'(8'hE0 + i), 1'b0);
        rst = 1'b1;
        tick();
        check("midrst_out_vld", 64'(out_vld), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(8'(8'h11 + i), 1'b0);
        check("midrst_data", out_data, 64'h1817161514131211);
        check("midrst_beats", 64'(out_beats), 64'd8);
        tick();
        check("midrst_one_word", 64'(out_vld), 64'd0);

        // Randomised traffic, including occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            in_vld  = ($urandom_range(0, 3) != 0);
            in_data = 8'($urandom);
            in_last = ($urandom_range(0, 5) == 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            tick();
        end

        // Drain
        rst     = 1'b0;
        in_vld  = 1'b0;
        in_last = 1'b0;
        out_rdy = 1'b1;
        repeat (5) tick();
        check("drained_vld", 64'(out_vld), 64'd0);
        run1 = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multisim_client_push_packer.md
Name: multisim_client_push_packer

Overview:
- Upstream feeder for the multisim client push stage.
- Gathers narrow DUT-side beats into one DATA_WIDTH word and presents it on a valid/ready interface that drives the client push's data_vld/data_rdy/data.
- Cuts the timing path from the client's data_rdy back to the DUT, because in_rdy is fully registered.
- Supports early flush of a partial word with in_last.

Parameters:
IN_WIDTH, 8, width of one input beat
DATA_WIDTH, 64, width of the packed output word; must be an integer multiple of IN_WIDTH (elaboration error otherwise)
RATIO, DATA_WIDTH/IN_WIDTH (localparam), beats per full word
CNT_WIDTH, $clog2(RATIO)+1 (localparam), width of out_beats

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
in_vld  input  1  input beat valid
in_rdy  output  1  input beat ready; registered, no combinational path from any input
in_data  input  IN_WIDTH  input beat
in_last  input  1  qualifies in_vld; closes the current word after this beat
out_vld  output  1  packed word valid; connects to the client push data_vld
out_rdy  input  1  packed word ready; connects to the client push data_rdy
out_data  output  DATA_WIDTH  packed word
out_beats  output  CNT_WIDTH  number of valid beats in out_data, 1..RATIO

Behaviour:
- Input handshake fires when in_vld && in_rdy. Output handshake fires when out_vld && out_rdy.
- Beat packing: beat k of a word (k = 0..RATIO-1) lands in out_data[k*IN_WIDTH +: IN_WIDTH]. The first beat goes to the LSBs. Unfilled lanes of a partial word are zero.
- Storage is an accumulator (acc_data, beat_cnt 0..RATIO-1) plus an output register (out_data/out_beats/out_vld).
- State machine:
  - OPEN: accumulator accepts beats; in_rdy=1.
  - CLOSED: accumulator holds a completed word that could not move to the output register; in_rdy=0.
- Word completion: an accepted beat completes the word when beat_cnt==RATIO-1 or in_last=1.
- On completion, the word is moved to the output register at that same edge if the output register is free, i.e. !out_vld, or out_vld && out_rdy in that cycle:
  - out_vld=1 from the next cycle (latency 1 edge from the final beat);
  - beat_cnt returns to 0;
  - the state stays OPEN.
- If the output register is not free on completion, go to CLOSED. In CLOSED, the first edge where out_vld && out_rdy=1 moves the accumulator into the output register, clears the accumulator, and returns to OPEN (in_rdy=1 next cycle).
- Output register behaviour:
  - On an output handshake with no new word arriving, out_vld goes to 0 at the next edge.
  - While out_vld && !out_rdy, out_data and out_beats are held stable.
- Throughput: one beat per cycle sustained whenever out_rdy=1 at each word completion.
- in_last with beat_cnt==RATIO-1 is treated as a full word: out_beats=RATIO.
- in_last on the first beat produces a 1-beat word with out_beats=1.
- No empty words are ever emitted. in_data and in_last are ignored when in_vld=0.
- RATIO=1: every accepted beat is a full word; the block behaves as a 1-deep registered pipeline stage.
- Reset (any cycle, including mid-word or in CLOSED):
  - outputs next cycle: out_vld=0, out_data=0, out_beats=0;
  - internal: beat_cnt=0, acc_data=0, state=OPEN;
  - in_rdy=0 while rst=1 and 1 in the first cycle after rst deasserts;
  - a partial word and any pending output word are discarded.

Test Plan:
- Full word, DATA_WIDTH=64, IN_WIDTH=8, out_rdy=1: beats 0x01..0x08 on consecutive cycles -> one word 0x0807060504030201, out_beats=8, out_vld high the cycle after the 8th beat, for exactly 1 cycle.
- Partial flush: beats 0xAA, 0xBB, 0xCC with in_last on 0xCC -> out_data=0x0000000000CCBBAA, out_beats=3; next word starts again at lane 0.
- Backpressure: out_rdy=0, offer 16 beats 0x00..0x0F -> word 0 is held stable on out_data; in_rdy=0 the cycle after the 16th beat (CLOSED).
  - Then raise out_rdy -> words 0x0706050403020100 then 0x0F0E0D0C0B0A0908 in order, and in_rdy=1 again.
- Streaming with out_rdy=1: 64 continuous beats -> 8 words, in_rdy never drops, each out_vld pulse 1 cycle after its 8th beat.
- Reset mid-operation: 5 beats accepted, then rst for 1 cycle, then 8 beats 0x11..0x18 -> exactly one word 0x1817161514131211; out_vld=0 the cycle after rst.
- Corner cases:
  - in_last on the 8th beat -> out_beats=8.
  - in_last on the first beat 0x5A -> out_data=0x5A, out_beats=1.
  - RATIO=1 build (IN_WIDTH=64) -> each beat appears on out_data 1 cycle later with out_beats=1.
